// File: rtl/draw_pixel_sink.sv
// Drawer-FSM pixel sink: clips latched pixels, buffers them in a FWFT FIFO and
// drives the VGA write port. Optional colour keying under DRAW_PIXEL_SINK_TRANSPARENT_EN.
module draw_pixel_sink #(
  parameter int         SCREEN_W           = 320,
  parameter int         SCREEN_H           = 240,
  parameter int         FIFO_DEPTH         = 4,
  parameter logic [8:0] TRANSPARENT_COLOUR = 9'h1C7
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ld_xy,
  input  logic        ld_pos,
  input  logic        ld_colour,
  input  logic        draw_pixel,
  input  logic        done_in,
  input  logic [8:0]  x_in,
  input  logic [8:0]  y_in,
  input  logic [8:0]  dx,
  input  logic [8:0]  dy,
  input  logic [8:0]  colour_in,
  input  logic        clr_stats,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [8:0]  vga_colour,
  output logic        vga_plot,
  input  logic        vga_ready,
  output logic        frame_done,
  output logic        idle,
  output logic        overflow,
  output logic [16:0] pix_count
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam int            EW      = 26;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [9:0]    W_LIM   = 10'(SCREEN_W);
  localparam logic [9:0]    H_LIM   = 10'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic            frame_done_q;
  logic [8:0]      base_x_q, base_x_d, base_y_q, base_y_d;
  logic [9:0]      pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [8:0]      col_q, col_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [16:0]     pix_count_q, pix_count_d;
  logic            skip, in_range, full, pop, push, drop;
  logic [EW-1:0]   entry, head;

`ifdef DRAW_PIXEL_SINK_TRANSPARENT_EN
  assign skip = (col_q == TRANSPARENT_COLOUR);
`else
  logic [8:0] unused_tc;
  assign unused_tc = TRANSPARENT_COLOUR;
  assign skip      = 1'b0;
`endif

  always_comb begin
    in_range = (pos_x_q < W_LIM) && (pos_y_q < H_LIM) && !skip;
    full     = (count_q == DEPTH_C);
    pop      = (count_q != '0) && vga_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    push     = draw_pixel && in_range && (!full || pop);
    drop     = draw_pixel && in_range && full && !pop;
    entry    = {pos_x_q[8:0], pos_y_q[7:0], col_q};

    base_x_d = ld_xy ? x_in : base_x_q;
    base_y_d = ld_xy ? y_in : base_y_q;
    pos_x_d  = ld_pos ? ({1'b0, base_x_q} + {1'b0, dx}) : pos_x_q;
    pos_y_d  = ld_pos ? ({1'b0, base_y_q} + {1'b0, dy}) : pos_y_q;
    col_d    = ld_colour ? colour_in : col_q;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    overflow_d  = overflow_q;
    pix_count_d = pix_count_q;
    if (clr_stats) begin
      overflow_d  = 1'b0;
      pix_count_d = '0;
    end else begin
      if (drop) overflow_d = 1'b1;
      if (push && pix_count_q != 17'h1FFFF) pix_count_d = pix_count_q + 17'd1;
    end
  end

  // When empty the slot behind rd_ptr still holds the last popped pixel.
  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : mem_q[rd_ptr_q - 1'b1];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      base_x_q    <= '0;
      base_y_q    <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      col_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      pix_count_q <= '0;
    end else begin
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      col_q       <= col_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      pix_count_q <= pix_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE:   if (ld_xy) state_q <= S_ACTIVE;
        S_ACTIVE: if (done_in) state_q <= S_DRAIN;
        S_DRAIN:  if (count_d == '0) begin
                    state_q      <= S_DONE;
                    frame_done_q <= 1'b1;
                  end
        S_DONE:   state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign vga_x      = head[25:17];
  assign vga_y      = head[16:9];
  assign vga_colour = head[8:0];
  assign vga_plot   = (count_q != '0);
  assign frame_done = frame_done_q;
  assign idle       = (state_q == S_IDLE) && (count_q == '0);
  assign overflow   = overflow_q;
  assign pix_count  = pix_count_q;
endmodule

// File: tb/tb_draw_pixel_sink.sv
// Directed + randomized bench for draw_pixel_sink against a queue-based pixel model.
module tb_draw_pixel_sink;
  logic        clock = 1'b0, resetn = 1'b0;
  logic        ld_xy = 0, ld_pos = 0, ld_colour = 0, draw_pixel = 0, done_in = 0, clr_stats = 0;
  logic [8:0]  x_in = 0, y_in = 0, dx = 0, dy = 0, colour_in = 0;
  logic        vga_ready = 0;
  logic [8:0]  vga_x, vga_colour;
  logic [7:0]  vga_y;
  logic        vga_plot, frame_done, idle, overflow;
  logic [16:0] pix_count;

  always #5 clock = ~clock;

  draw_pixel_sink dut (
    .clock(clock), .resetn(resetn), .ld_xy(ld_xy), .ld_pos(ld_pos), .ld_colour(ld_colour),
    .draw_pixel(draw_pixel), .done_in(done_in), .x_in(x_in), .y_in(y_in), .dx(dx), .dy(dy),
    .colour_in(colour_in), .clr_stats(clr_stats), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .vga_ready(vga_ready),
    .frame_done(frame_done), .idle(idle), .overflow(overflow), .pix_count(pix_count)
  );

  typedef struct { int x; int y; int c; } pix_t;
  pix_t q[$];
  pix_t m_last;
  int   m_bx = 0, m_by = 0, m_px = 0, m_py = 0, m_col = 0, m_ovf = 0, m_cnt = 0;
  int   m_phase = 0;  // 0 idle, 1 drawing, 2 draining, 3 done
  int   n_tests = 0, n_fail = 0, fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: applies one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   do_pop, inr, do_push, do_drop;
    pix_t p;
    if (!resetn) begin
      q.delete();
      m_bx = 0; m_by = 0; m_px = 0; m_py = 0; m_col = 0; m_ovf = 0; m_cnt = 0;
      m_phase = 0; m_last = '{0, 0, 0};
      return;
    end
    do_pop = (q.size() != 0) && vga_ready;
    inr    = (m_px < 320) && (m_py < 240);
`ifdef DRAW_PIXEL_SINK_TRANSPARENT_EN
    if (m_col == 'h1C7) inr = 0;
`endif
    do_push = draw_pixel && inr && (q.size() < 4 || do_pop);
    do_drop = draw_pixel && inr && !do_push;
    if (do_pop) m_last = q.pop_front();
    if (do_push) begin
      p = '{m_px, m_py, m_col};
      q.push_back(p);
    end
    if (ld_pos) begin m_px = m_bx + int'(dx); m_py = m_by + int'(dy); end
    if (ld_xy) begin m_bx = int'(x_in); m_by = int'(y_in); end
    if (ld_colour) m_col = int'(colour_in);
    if (clr_stats) begin m_ovf = 0; m_cnt = 0; end
    else begin
      if (do_drop) m_ovf = 1;
      if (do_push && m_cnt < 131071) m_cnt++;
    end
    case (m_phase)
      0: if (ld_xy) m_phase = 1;
      1: if (done_in) m_phase = 2;
      2: if (q.size() == 0) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_outputs();
    pix_t h;
    h = (q.size() != 0) ? q[0] : m_last;
    chk("plot",       32'(vga_plot),   32'(q.size() != 0));
    chk("x",          32'(vga_x),      32'(h.x));
    chk("y",          32'(vga_y),      32'(h.y));
    chk("colour",     32'(vga_colour), 32'(h.c));
    chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
    chk("idle",       32'(idle),       32'(m_phase == 0 && q.size() == 0));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("pix_count",  32'(pix_count),  32'(m_cnt));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    if (frame_done) fd_seen++;
    check_outputs();
  endtask

  task automatic strobes_off();
    ld_xy = 0; ld_pos = 0; ld_colour = 0; draw_pixel = 0; done_in = 0; clr_stats = 0;
  endtask

  initial begin
    // Reset state
    resetn = 0; cyc(); cyc(); resetn = 1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_plot", 32'(vga_plot), 32'd0);

    // Single pixel at (35,225)
    vga_ready = 1;
    ld_xy = 1; x_in = 30; y_in = 222; cyc(); strobes_off();
    ld_pos = 1; dx = 5; dy = 3; ld_colour = 1; colour_in = 9'h1FF; cyc(); strobes_off();
    draw_pixel = 1; cyc(); strobes_off();
    chk("t1_plot", 32'(vga_plot), 32'd1);
    chk("t1_x", 32'(vga_x), 32'd35);
    chk("t1_y", 32'(vga_y), 32'd225);
    chk("t1_col", 32'(vga_colour), 32'h1FF);
    chk("t1_cnt", 32'(pix_count), 32'd1);
    cyc();
    chk("t1_plot_lo", 32'(vga_plot), 32'd0);

    // Right-edge clipping: x=319 kept, x=320 dropped
    ld_xy = 1; x_in = 300; y_in = 10; clr_stats = 1; cyc(); strobes_off();
    ld_pos = 1; dx = 19; dy = 0; cyc(); strobes_off();
    draw_pixel = 1; ld_pos = 1; dx = 20; cyc(); strobes_off();
    chk("t2_x", 32'(vga_x), 32'd319);
    draw_pixel = 1; cyc(); strobes_off();
    cyc();
    chk("t2_plot", 32'(vga_plot), 32'd0);
    chk("t2_ovf", 32'(overflow), 32'd0);
    chk("t2_cnt", 32'(pix_count), 32'd1);

    // Overflow with stalled adapter, then in-order drain
    vga_ready = 0;
    ld_xy = 1; x_in = 100; y_in = 50; clr_stats = 1; cyc(); strobes_off();
    ld_pos = 1; dx = 0; dy = 0; ld_colour = 1; colour_in = 9'h0AA; cyc(); strobes_off();
    for (int i = 0; i < 5; i++) begin
      draw_pixel = 1; ld_pos = 1; dx = 9'(i + 1); cyc(); strobes_off();
    end
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_cnt", 32'(pix_count), 32'd4);
    vga_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_order", 32'(vga_x), 32'(100 + k));
      cyc();
    end
    chk("t3_empty", 32'(vga_plot), 32'd0);

    // Full FIFO: push with simultaneous pop is accepted; clr_stats beats increment
    vga_ready = 0;
    for (int i = 0; i < 4; i++) begin draw_pixel = 1; cyc(); strobes_off(); end
    clr_stats = 1; cyc(); strobes_off();
    vga_ready = 1; draw_pixel = 1; cyc(); strobes_off();
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_cnt", 32'(pix_count), 32'd1);
    draw_pixel = 1; clr_stats = 1; cyc(); strobes_off();
    chk("t4_clr", 32'(pix_count), 32'd0);
    for (int i = 0; i < 6; i++) cyc();
    done_in = 1; cyc(); strobes_off();
    for (int i = 0; i < 4; i++) cyc();

    // frame_done after drain
    fd_seen = 0; vga_ready = 0;
    ld_xy = 1; x_in = 10; y_in = 10; cyc(); strobes_off();
    ld_pos = 1; dx = 1; dy = 0; ld_colour = 1; colour_in = 9'h055; cyc(); strobes_off();
    draw_pixel = 1; ld_pos = 1; dx = 2; cyc(); strobes_off();
    draw_pixel = 1; ld_pos = 1; dx = 3; cyc(); strobes_off();
    draw_pixel = 1; done_in = 1; cyc(); strobes_off();
    for (int i = 0; i < 10; i++) cyc();
    chk("t5_no_fd", 32'(fd_seen), 32'd0);
    vga_ready = 1;
    cyc(); cyc(); cyc();
    chk("t5_fd", 32'(frame_done), 32'd1);
    cyc();
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_fd_once", 32'(fd_seen), 32'd1);

    // Reset while draining flushes without frame_done
    vga_ready = 0;
    ld_xy = 1; x_in = 20; y_in = 20; cyc(); strobes_off();
    ld_pos = 1; dx = 0; dy = 0; ld_colour = 1; colour_in = 9'h011; cyc(); strobes_off();
    draw_pixel = 1; cyc(); cyc(); strobes_off();
    done_in = 1; cyc(); strobes_off();
    resetn = 0; cyc(); resetn = 1;
    chk("t6_plot", 32'(vga_plot), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    cyc();
    chk("t6_no_fd", 32'(frame_done), 32'd0);

    // Colour-key pixel
    vga_ready = 1;
    ld_xy = 1; x_in = 5; y_in = 5; cyc(); strobes_off();
    ld_pos = 1; dx = 0; dy = 0; ld_colour = 1; colour_in = 9'h1C7; cyc(); strobes_off();
    draw_pixel = 1; cyc(); strobes_off();
`ifdef DRAW_PIXEL_SINK_TRANSPARENT_EN
    chk("t7_key", 32'(vga_plot), 32'd0);
`else
    chk("t7_key", 32'(vga_plot), 32'd1);
`endif
    cyc();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      resetn     = ($urandom_range(0, 199) != 0);
      ld_xy      = ($urandom_range(0, 7) == 0);
      ld_pos     = ($urandom_range(0, 1) == 0);
      ld_colour  = ($urandom_range(0, 2) == 0);
      draw_pixel = ($urandom_range(0, 1) == 0);
      done_in    = ($urandom_range(0, 9) == 0);
      clr_stats  = ($urandom_range(0, 49) == 0);
      vga_ready  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) begin
        x_in = 9'($urandom_range(0, 511)); y_in = 9'($urandom_range(0, 511));
        dx   = 9'($urandom_range(0, 511)); dy   = 9'($urandom_range(0, 511));
      end else begin
        x_in = 9'($urandom_range(0, 310)); y_in = 9'($urandom_range(0, 235));
        dx   = 9'($urandom_range(0, 15));  dy   = 9'($urandom_range(0, 8));
      end
      colour_in = ($urandom_range(0, 5) == 0) ? 9'h1C7 : 9'($urandom_range(0, 511));
      cyc();
    end
    strobes_off(); resetn = 1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
